// File: rtl/fft_pkg.sv
// fft_pkg: shared definitions for the FFT twiddle path.
//   - state_t          : sequencing states of twiddle_cmul_seq
//   - DEF_WIDTH        : default component width
//   - K_RR..K_IR       : order in which the four real products are issued
//   - SAT_MAX/SAT_MIN  : saturation limits for the default width
package fft_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    ROUND = 3'd3,
    OUT   = 3'd4
  } state_t;

  localparam int DEF_WIDTH = 8;

  // Product order: k=0 ar*wr (+re), k=1 ai*wi (-re), k=2 ar*wi (+im), k=3 ai*wr (+im)
  localparam logic [1:0] K_RR = 2'd0;
  localparam logic [1:0] K_II = 2'd1;
  localparam logic [1:0] K_RI = 2'd2;
  localparam logic [1:0] K_IR = 2'd3;

  localparam int SAT_MAX = (2 ** (DEF_WIDTH - 1)) - 1;
  localparam int SAT_MIN = -(2 ** (DEF_WIDTH - 1));

endpackage

// File: rtl/cplx_round_sat.sv
// cplx_round_sat: combinational round + arithmetic shift + saturate of one
// accumulator back to WIDTH bits.
//   acc : 2*WIDTH+1 bit signed accumulator
//   y   : WIDTH bit signed, saturated result
// Build option TWID_ROUND_EN: when defined, 2^(FRAC-1) is added before the
// shift (round half up); otherwise the shift truncates toward -inf.
module cplx_round_sat
  import fft_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FRAC  = WIDTH - 1
) (
  input  logic signed [2*WIDTH:0]  acc,
  output logic signed [WIDTH-1:0]  y
);

  // One guard bit above the accumulator so the rounding bias cannot wrap.
  localparam int AW = 2 * WIDTH + 2;
  localparam logic signed [AW-1:0] MAX_V = AW'((2 ** (WIDTH - 1)) - 1);
  localparam logic signed [AW-1:0] MIN_V = AW'(-(2 ** (WIDTH - 1)));
`ifdef TWID_ROUND_EN
  localparam logic signed [AW-1:0] RND_BIAS = AW'(2 ** (FRAC - 1));
`endif

  logic signed [AW-1:0] ext_s;
  logic signed [AW-1:0] rnd_s;
  logic signed [AW-1:0] shf_s;

  // Extend, optionally bias, shift and clamp to the WIDTH-bit signed range.
  always_comb begin
    ext_s = {acc[2*WIDTH], acc};
`ifdef TWID_ROUND_EN
    rnd_s = ext_s + RND_BIAS;
`else
    rnd_s = ext_s;
`endif
    shf_s = rnd_s >>> FRAC;
    if (shf_s > MAX_V) begin
      y = MAX_V[WIDTH-1:0];
    end else if (shf_s < MIN_V) begin
      y = MIN_V[WIDTH-1:0];
    end else begin
      y = shf_s[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/twiddle_cmul_seq.sv
// twiddle_cmul_seq: sequential complex multiply Y = A*W for the FFT butterfly.
// The four real products are issued one at a time to an external shared
// `multiply` instance, accumulated, then rounded/saturated to WIDTH bits.
//   clkin, rst             : clock, synchronous active-high reset
//   in_valid/in_ready      : operand handshake (ar, ai, wr, wi)
//   out_valid/out_ready    : result handshake (yr, yi)
//   mul_a/mul_b            : registered operands to multiply a_in/b_in
//   mul_ready/mul_product  : multiply status and signed product
// Build option TWID_ROUND_EN selects round-half-up instead of truncation
// (inside cplx_round_sat); cycle timing is unaffected.
module twiddle_cmul_seq
  import fft_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FRAC  = WIDTH - 1
) (
  input  logic                     clkin,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [WIDTH-1:0]  ar,
  input  logic signed [WIDTH-1:0]  ai,
  input  logic signed [WIDTH-1:0]  wr,
  input  logic signed [WIDTH-1:0]  wi,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [WIDTH-1:0]  yr,
  output logic signed [WIDTH-1:0]  yi,
  output logic signed [WIDTH-1:0]  mul_a,
  output logic signed [WIDTH-1:0]  mul_b,
  input  logic                     mul_ready,
  input  logic signed [2*WIDTH-2:0] mul_product
);

  localparam logic signed [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] NEG_CLAMP = {1'b1, {(WIDTH-2){1'b0}}, 1'b1};

  // The product field cannot hold (-2^(W-1))^2, so the most negative code is
  // pulled in by one before it ever reaches the multiplier.
  function automatic logic signed [WIDTH-1:0] clamp_neg(input logic signed [WIDTH-1:0] v);
    if (v == MOST_NEG) begin
      return NEG_CLAMP;
    end else begin
      return v;
    end
  endfunction

  state_t                    state_r;
  logic [1:0]                k_r;
  logic signed [WIDTH-1:0]   op_ar_r;
  logic signed [WIDTH-1:0]   op_ai_r;
  logic signed [WIDTH-1:0]   op_wr_r;
  logic signed [WIDTH-1:0]   op_wi_r;
  logic signed [2*WIDTH:0]   acc_re_r;
  logic signed [2*WIDTH:0]   acc_im_r;

  logic [1:0]                k_nxt_s;
  logic signed [WIDTH-1:0]   nxt_a_s;
  logic signed [WIDTH-1:0]   nxt_b_s;
  logic signed [2*WIDTH:0]   prod_ext_s;
  logic signed [WIDTH-1:0]   rnd_re_s;
  logic signed [WIDTH-1:0]   rnd_im_s;

  // Operands for the next product: k odd takes ai, else ar; b takes wi for k=1,2.
  always_comb begin
    k_nxt_s    = k_r + 2'd1;
    nxt_a_s    = k_nxt_s[0] ? op_ai_r : op_ar_r;
    nxt_b_s    = (k_nxt_s[0] ^ k_nxt_s[1]) ? op_wi_r : op_wr_r;
    prod_ext_s = {{2{mul_product[2*WIDTH-2]}}, mul_product};
  end

  cplx_round_sat #(.WIDTH(WIDTH), .FRAC(FRAC)) u_rs_re (
    .acc (acc_re_r),
    .y   (rnd_re_s)
  );

  cplx_round_sat #(.WIDTH(WIDTH), .FRAC(FRAC)) u_rs_im (
    .acc (acc_im_r),
    .y   (rnd_im_s)
  );

  // Sequencing FSM with registered handshake, multiplier and result outputs.
  always_ff @(posedge clkin) begin
    if (rst) begin
      state_r   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      yr        <= '0;
      yi        <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      acc_re_r  <= '0;
      acc_im_r  <= '0;
      k_r       <= K_RR;
      op_ar_r   <= '0;
      op_ai_r   <= '0;
      op_wr_r   <= '0;
      op_wi_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            op_ar_r  <= clamp_neg(ar);
            op_ai_r  <= clamp_neg(ai);
            op_wr_r  <= clamp_neg(wr);
            op_wi_r  <= clamp_neg(wi);
            mul_a    <= clamp_neg(ar);
            mul_b    <= clamp_neg(wr);
            acc_re_r <= '0;
            acc_im_r <= '0;
            k_r      <= K_RR;
            in_ready <= 1'b0;
            state_r  <= ISSUE;
          end
        end
        // mul_ready is stale here: it only reflects the new operands next cycle.
        ISSUE: begin
          state_r <= WAIT;
        end
        WAIT: begin
          if (mul_ready) begin
            case (k_r)
              K_RR:    acc_re_r <= acc_re_r + prod_ext_s;
              K_II:    acc_re_r <= acc_re_r - prod_ext_s;
              K_RI:    acc_im_r <= acc_im_r + prod_ext_s;
              K_IR:    acc_im_r <= acc_im_r + prod_ext_s;
              default: acc_im_r <= acc_im_r;
            endcase
            if (k_r != K_IR) begin
              k_r     <= k_nxt_s;
              mul_a   <= nxt_a_s;
              mul_b   <= nxt_b_s;
              state_r <= ISSUE;
            end else begin
              state_r <= ROUND;
            end
          end
        end
        ROUND: begin
          yr        <= rnd_re_s;
          yi        <= rnd_im_s;
          out_valid <= 1'b1;
          state_r   <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_r   <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_twiddle_cmul_seq.sv
// tb_twiddle_cmul_seq: directed scoreboard bench for twiddle_cmul_seq with an
// iterative multiplier model (ready drops on operand change, ITER cycles busy).
module tb_twiddle_cmul_seq;

  localparam int W    = 8;
  localparam int ITER = 4;
`ifdef TWID_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, mul_ready;
  logic signed [W-1:0] ar, ai, wr, wi, yr, yi, mul_a, mul_b;
  logic signed [2*W-2:0] mul_product;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  twiddle_cmul_seq #(.WIDTH(W)) dut (
    .clkin(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ar(ar), .ai(ai), .wr(wr), .wi(wi),
    .out_valid(out_valid), .out_ready(out_ready), .yr(yr), .yi(yi),
    .mul_a(mul_a), .mul_b(mul_b), .mul_ready(mul_ready), .mul_product(mul_product)
  );

  // Iterative multiplier model
  logic signed [W-1:0] m_a_q = '0;
  logic signed [W-1:0] m_b_q = '0;
  int m_cnt = 0;
  logic signed [2*W-1:0] m_full;
  always @(posedge clk) begin
    if (mul_a != m_a_q || mul_b != m_b_q) begin
      m_a_q <= mul_a;
      m_b_q <= mul_b;
      m_cnt <= ITER;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
    end
  end
  assign m_full      = (2*W)'(m_a_q) * (2*W)'(m_b_q);
  assign mul_product = m_full[2*W-2:0];
  assign mul_ready   = (mul_a == m_a_q) && (mul_b == m_b_q) && (m_cnt == 0);

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: compare every delivered result with the scoreboard head
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        check("yr", int'(yr), int'($signed(e[15:8])));
        check("yi", int'(yi), int'($signed(e[7:0])));
      end
    end
  end

  task automatic send(input int a_r, input int a_i, input int w_r, input int w_i,
                      input int e_r, input int e_i);
    logic signed [7:0] er8, ei8;
    bit done;
    done = 1'b0;
    er8 = 8'(e_r);
    ei8 = 8'(e_i);
    ar = 8'(a_r); ai = 8'(a_i); wr = 8'(w_r); wi = 8'(w_i);
    in_valid = 1'b1;
    for (int t = 0; t < 200 && !done; t++) begin
      if (in_ready) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        exp_q.push_back({er8, ei8});
        done = 1'b1;
      end else begin
        @(posedge clk); #1;
      end
    end
    if (!done) begin
      in_valid = 1'b0;
      check("accept_timeout", 0, 1);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain_timeout", int'(t < 500), 1);
  endtask

  initial begin
    int n;
    logic signed [W-1:0] hr, hi;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    ar = '0; ai = '0; wr = '0; wi = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_yr", int'(yr), 0);
    check("rst_yi", int'(yi), 0);
    check("rst_mul_a", int'(mul_a), 0);
    check("rst_mul_b", int'(mul_b), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Latency: four (ISSUE + WAIT of ITER+1) then ROUND
    send(64, 0, 127, 0, RND ? 64 : 63, 0);
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", n, 4 * (1 + ITER + 1) + 1);
    drain();

    send(64, 64, 0, 127, RND ? -63 : -64, RND ? 64 : 63);
    send(127, -127, 127, 127, 127, 0);
    send(-128, 0, 127, 0, RND ? -126 : -127, 0);
    send(-127, 127, 127, 127, -128, 0);
    send(64, 64, 64, 64, 0, 64);
    send(-128, -128, -128, -128, 0, 127);
    drain();

    // Backpressure: result held while out_ready low, no accept in OUT
    out_ready = 1'b0;
    send(64, 0, 127, 0, RND ? 64 : 63, 0);
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("hold_reach_out", int'(out_valid), 1);
    hr = yr; hi = yi;
    ar = 8'sd64; ai = 8'sd64; wr = 8'sd0; wi = 8'sd127;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("hold_out_valid", int'(out_valid), 1);
      check("hold_yr", int'(yr), int'(hr));
      check("hold_yi", int'(yi), int'(hi));
      check("hold_in_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("post_hs_in_ready", int'(in_ready), 1);
    check("post_hs_out_valid", int'(out_valid), 0);
    @(posedge clk); #1;
    check("second_accept", int'(in_ready), 0);
    in_valid = 1'b0;
    exp_q.push_back({8'(RND ? -63 : -64), 8'(RND ? 64 : 63)});
    drain();

    // Reset during WAIT of k=2 (ar*wi operands on the multiplier)
    ar = 8'sd10; ai = 8'sd20; wr = 8'sd30; wi = 8'sd40;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!(mul_a == 8'sd10 && mul_b == 8'sd40) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("reach_k2", int'(n < 200), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_in_ready", int'(in_ready), 1);
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_yr", int'(yr), 0);
    check("mid_rst_yi", int'(yi), 0);
    check("mid_rst_mul_a", int'(mul_a), 0);
    repeat (40) @(posedge clk);
    #1;
    check("mid_rst_no_output", int'(out_valid), 0);
    send(10, 20, 30, 40, -4, RND ? 8 : 7);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
